ifu_jalr_rs1_rdctl: RTL and testbench

//  Sequences register-file read port 1 for JALR instructions whose rs1 is neither x0 nor x1 (rs1xn).

---
 rtl/ifu_jalr_rs1_rdctl_if.sv | 35 +++
 rtl/ifu_jalr_rs1_rdctl.sv | 197 +++++++++++++++++++
 tb/tb_ifu_jalr_rs1_rdctl.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ifu_jalr_rs1_rdctl_if.sv
// Bundle of the JALR rs1 read-control signals between the IFU mini-decoder/BPU,
// the EXU operand-read requester and regfile read port 1.
// The slave modport is the controller's view; master is the surrounding pipeline.
interface ifu_jalr_rs1_rdctl_if #(
    parameter int RFIDX_W = 5,
    parameter int XLEN    = 32
);
    logic               jalr_req;
    logic [RFIDX_W-1:0] jalr_rs1idx;
    logic               dep_clr;
    logic               jalr_ack;
    logic               flush;
    logic               exu_rs1_req;
    logic               exu_rs1_gnt;
    logic               bpu_rs1_gnt;
    logic [RFIDX_W-1:0] rf_rs1_idx;
    logic [XLEN-1:0]    rf_rs1_rdata;
    logic [XLEN-1:0]    rs1_val;
    logic               rs1_vld;
    logic               bpu_wait;
    logic               wb_ena;
    logic [RFIDX_W-1:0] wb_idx;

    modport slave (
        input  jalr_req, jalr_rs1idx, dep_clr, jalr_ack, flush, exu_rs1_req,
        input  rf_rs1_rdata, wb_ena, wb_idx,
        output exu_rs1_gnt, bpu_rs1_gnt, rf_rs1_idx, rs1_val, rs1_vld, bpu_wait
    );

    modport master (
        output jalr_req, jalr_rs1idx, dep_clr, jalr_ack, flush, exu_rs1_req,
        output rf_rs1_rdata, wb_ena, wb_idx,
        input  exu_rs1_gnt, bpu_rs1_gnt, rf_rs1_idx, rs1_val, rs1_vld, bpu_wait
    );
endinterface

// File: rtl/ifu_jalr_rs1_rdctl.sv
// JALR rs1 read controller: sequences regfile read port 1 for JALR instructions
// whose rs1 is neither x0 nor x1, shares the port with the EXU (starvation-
// protected), and holds the captured rs1 value as the JALR target base until
// decode acknowledges it.
// Optional feature: define IFU_JALR_RS1_CACHE_EN to add a one-entry rs1 cache
// that lets a repeated JALR on the same index skip the regfile read.
module ifu_jalr_rs1_rdctl #(
    parameter int RFIDX_W    = 5,
    parameter int XLEN       = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    ifu_jalr_rs1_rdctl_if.slave bus
);

    localparam logic [3:0] STARVE_MAX_C = 4'(STARVE_MAX);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_DEP  = 3'd1,
        ST_ARB  = 3'd2,
        ST_RD   = 3'd3,
        ST_HOLD = 3'd4
    } state_t;

    state_t          state_r;
    state_t          state_s;
    logic [3:0]      starve_r;
    logic [3:0]      starve_s;
    logic [XLEN-1:0] rs1_q_r;
    logic            bpu_win_s;
    logic            bpu_gnt_s;
    logic            capture_s;
    logic            hit_take_s;
    logic            cache_hit_s;

`ifdef IFU_JALR_RS1_CACHE_EN
    logic               c_vld_r;
    logic [RFIDX_W-1:0] c_idx_r;
    logic [XLEN-1:0]    c_val_r;
    logic [RFIDX_W-1:0] rd_idx_r;
    logic               wb_hits_cache_s;
    logic               wb_hits_rd_s;

    assign wb_hits_cache_s = bus.wb_ena & (bus.wb_idx == c_idx_r);
    assign wb_hits_rd_s    = bus.wb_ena & (bus.wb_idx == rd_idx_r);
    // A write landing on the cached index in the same cycle makes the entry stale,
    // so it cannot be used as a hit.
    assign cache_hit_s     = c_vld_r & (c_idx_r == bus.jalr_rs1idx) & ~wb_hits_cache_s;
`else
    assign cache_hit_s     = 1'b0;
`endif

    // Regfile write port only matters when the cache is built in.
    logic unused_wb_s;
    assign unused_wb_s = ^{bus.wb_ena, bus.wb_idx};

    assign bpu_win_s = ~bus.exu_rs1_req | (starve_r == STARVE_MAX_C);

    // Next-state, grant and capture decode; flush overrides the state but not a grant already issued.
    always_comb begin
        state_s    = state_r;
        starve_s   = 4'd0;
        bpu_gnt_s  = 1'b0;
        capture_s  = 1'b0;
        hit_take_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.jalr_req) begin
                    if (bus.dep_clr) begin
                        if (cache_hit_s) begin
                            state_s    = ST_HOLD;
                            hit_take_s = 1'b1;
                        end else begin
                            state_s = ST_ARB;
                        end
                    end else begin
                        state_s = ST_DEP;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_DEP: begin
                if (!bus.jalr_req) begin
                    state_s = ST_IDLE;
                end else if (bus.dep_clr) begin
                    state_s = ST_ARB;
                end else begin
                    state_s = ST_DEP;
                end
            end
            ST_ARB: begin
                if (!bus.jalr_req) begin
                    state_s = ST_IDLE;
                end else if (bpu_win_s) begin
                    bpu_gnt_s = 1'b1;
                    state_s   = ST_RD;
                end else begin
                    state_s  = ST_ARB;
                    starve_s = (starve_r == STARVE_MAX_C) ? starve_r : (starve_r + 4'd1);
                end
            end
            ST_RD: begin
                capture_s = 1'b1;
                state_s   = ST_HOLD;
            end
            ST_HOLD: begin
                if (bus.jalr_ack) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_HOLD;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase

        if (bus.flush) begin
            state_s    = ST_IDLE;
            starve_s   = 4'd0;
            capture_s  = 1'b0;
            hit_take_s = 1'b0;
        end else begin
            state_s = state_s;
        end
    end

    // State and starvation counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            starve_r <= 4'd0;
        end else begin
            state_r  <= state_s;
            starve_r <= starve_s;
        end
    end

    // Captured JALR base: regfile data in RD, or the cached value on a hit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rs1_q_r <= {XLEN{1'b0}};
        end else if (capture_s) begin
            rs1_q_r <= bus.rf_rs1_rdata;
`ifdef IFU_JALR_RS1_CACHE_EN
        end else if (hit_take_s) begin
            rs1_q_r <= c_val_r;
`endif
        end else begin
            rs1_q_r <= rs1_q_r;
        end
    end

`ifdef IFU_JALR_RS1_CACHE_EN
    // Remember the index actually granted so the cache tags the data it receives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_idx_r <= {RFIDX_W{1'b0}};
        end else if (bpu_gnt_s) begin
            rd_idx_r <= bus.jalr_rs1idx;
        end else begin
            rd_idx_r <= rd_idx_r;
        end
    end

    // One-entry cache fill on RD capture, invalidated by writes to its index; flush keeps it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_vld_r <= 1'b0;
            c_idx_r <= {RFIDX_W{1'b0}};
            c_val_r <= {XLEN{1'b0}};
        end else if (capture_s) begin
            c_vld_r <= ~wb_hits_rd_s;
            c_idx_r <= rd_idx_r;
            c_val_r <= bus.rf_rs1_rdata;
        end else if (wb_hits_cache_s) begin
            c_vld_r <= 1'b0;
        end else begin
            c_vld_r <= c_vld_r;
        end
    end
`else
    logic unused_hit_s;
    assign unused_hit_s = hit_take_s;
`endif

    assign bus.bpu_rs1_gnt = bpu_gnt_s;
    assign bus.exu_rs1_gnt = bus.exu_rs1_req & ~bpu_gnt_s;
    assign bus.rf_rs1_idx  = bpu_gnt_s ? bus.jalr_rs1idx : {RFIDX_W{1'b0}};
    assign bus.rs1_val     = rs1_q_r;
    assign bus.rs1_vld     = (state_r == ST_HOLD);
    assign bus.bpu_wait    = bus.jalr_req & (state_r != ST_HOLD);

endmodule

// File: tb/tb_ifu_jalr_rs1_rdctl.sv
// Directed self-checking bench for ifu_jalr_rs1_rdctl.
module tb_ifu_jalr_rs1_rdctl;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    ifu_jalr_rs1_rdctl_if #(.RFIDX_W(5), .XLEN(32)) bus ();

    ifu_jalr_rs1_rdctl #(.RFIDX_W(5), .XLEN(32), .STARVE_MAX(4)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one JALR from IDLE through ARB and RD into HOLD (no EXU contention).
    task automatic to_hold(input logic [4:0] idx, input logic [31:0] data);
        bus.jalr_req     = 1'b1;
        bus.dep_clr      = 1'b1;
        bus.jalr_rs1idx  = idx;
        bus.rf_rs1_rdata = 32'hDEAD_BEEF;
        tick();                 // ARB
        bus.rf_rs1_rdata = data;
        tick();                 // RD
        tick();                 // HOLD
    endtask

    task automatic release_jalr();
        bus.jalr_ack = 1'b1;
        bus.jalr_req = 1'b0;
        tick();
        bus.jalr_ack = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.jalr_req = 1'b0; bus.jalr_rs1idx = 5'd0; bus.dep_clr = 1'b0;
        bus.jalr_ack = 1'b0; bus.flush = 1'b0; bus.exu_rs1_req = 1'b0;
        bus.rf_rs1_rdata = 32'd0; bus.wb_ena = 1'b0; bus.wb_idx = 5'd0;
        tick(); tick();
        checks++;
        if ({bus.exu_rs1_gnt, bus.bpu_rs1_gnt, bus.rs1_vld, bus.bpu_wait} !== 4'b0000 ||
            bus.rf_rs1_idx !== 5'd0 || bus.rs1_val !== 32'd0) begin
            errors++;
            $display("FAIL reset_outputs got gnt=%b%b vld=%b wait=%b idx=%0d val=%h want all 0",
                     bus.exu_rs1_gnt, bus.bpu_rs1_gnt, bus.rs1_vld, bus.bpu_wait, bus.rf_rs1_idx, bus.rs1_val);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        bus.jalr_req = 1'b1; bus.dep_clr = 1'b1; bus.jalr_rs1idx = 5'd5;
        bus.rf_rs1_rdata = 32'hDEAD_BEEF;
        #1;
        checks++;
        if (bus.bpu_wait !== 1'b1 || bus.bpu_rs1_gnt !== 1'b0) begin
            errors++;
            $display("FAIL basic_idle got wait=%b gnt=%b want 1 0", bus.bpu_wait, bus.bpu_rs1_gnt);
        end
        tick();
        checks++;
        if (bus.bpu_rs1_gnt !== 1'b1 || bus.rf_rs1_idx !== 5'd5 || bus.exu_rs1_gnt !== 1'b0) begin
            errors++;
            $display("FAIL basic_gnt got gnt=%b idx=%0d exu=%b want 1 5 0", bus.bpu_rs1_gnt, bus.rf_rs1_idx, bus.exu_rs1_gnt);
        end
        bus.rf_rs1_rdata = 32'h8000_0100;
        tick();
        checks++;
        if (bus.bpu_rs1_gnt !== 1'b0 || bus.rs1_vld !== 1'b0 || bus.rf_rs1_idx !== 5'd0) begin
            errors++;
            $display("FAIL basic_rd got gnt=%b vld=%b idx=%0d want 0 0 0", bus.bpu_rs1_gnt, bus.rs1_vld, bus.rf_rs1_idx);
        end
        tick();
        checks++;
        if (bus.rs1_vld !== 1'b1 || bus.rs1_val !== 32'h8000_0100 || bus.bpu_wait !== 1'b0) begin
            errors++;
            $display("FAIL basic_hold got vld=%b val=%h wait=%b want 1 80000100 0", bus.rs1_vld, bus.rs1_val, bus.bpu_wait);
        end
        release_jalr();
        checks++;
        if (bus.rs1_vld !== 1'b0 || bus.rs1_val !== 32'h8000_0100) begin
            errors++;
            $display("FAIL basic_ack got vld=%b val=%h want 0 80000100", bus.rs1_vld, bus.rs1_val);
        end
    endtask

    task automatic test_dep();
        bus.jalr_req = 1'b1; bus.dep_clr = 1'b0; bus.jalr_rs1idx = 5'd7;
        for (int i = 0; i < 4; i++) begin
            // an ack outside HOLD must have no effect
            bus.jalr_ack = (i == 2);
            tick();
            checks++;
            if (bus.bpu_wait !== 1'b1 || bus.bpu_rs1_gnt !== 1'b0 || bus.rs1_vld !== 1'b0) begin
                errors++;
                $display("FAIL dep_wait cyc=%0d got wait=%b gnt=%b vld=%b want 1 0 0", i, bus.bpu_wait, bus.bpu_rs1_gnt, bus.rs1_vld);
            end
        end
        bus.jalr_ack = 1'b0;
        bus.dep_clr = 1'b1;
        #1;
        checks++;
        if (bus.bpu_rs1_gnt !== 1'b0) begin
            errors++;
            $display("FAIL dep_early_gnt got %b want 0", bus.bpu_rs1_gnt);
        end
        tick();
        checks++;
        if (bus.bpu_rs1_gnt !== 1'b1 || bus.rf_rs1_idx !== 5'd7 || bus.bpu_wait !== 1'b1) begin
            errors++;
            $display("FAIL dep_gnt got gnt=%b idx=%0d wait=%b want 1 7 1", bus.bpu_rs1_gnt, bus.rf_rs1_idx, bus.bpu_wait);
        end
        bus.rf_rs1_rdata = 32'h1234_5678;
        tick(); tick();
        checks++;
        if (bus.rs1_vld !== 1'b1 || bus.rs1_val !== 32'h1234_5678) begin
            errors++;
            $display("FAIL dep_hold got vld=%b val=%h want 1 12345678", bus.rs1_vld, bus.rs1_val);
        end
        release_jalr();
    endtask

    task automatic test_starve();
        bus.exu_rs1_req = 1'b1;
        bus.jalr_req = 1'b1; bus.dep_clr = 1'b1; bus.jalr_rs1idx = 5'd9;
        #1;
        checks++;
        if (bus.exu_rs1_gnt !== 1'b1 || bus.bpu_rs1_gnt !== 1'b0) begin
            errors++;
            $display("FAIL starve_idle_exu got exu=%b bpu=%b want 1 0", bus.exu_rs1_gnt, bus.bpu_rs1_gnt);
        end
        tick();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (bus.exu_rs1_gnt !== 1'b1 || bus.bpu_rs1_gnt !== 1'b0) begin
                errors++;
                $display("FAIL starve_exu_win cyc=%0d got exu=%b bpu=%b want 1 0", i, bus.exu_rs1_gnt, bus.bpu_rs1_gnt);
            end
            tick();
        end
        checks++;
        if (bus.bpu_rs1_gnt !== 1'b1 || bus.exu_rs1_gnt !== 1'b0) begin
            errors++;
            $display("FAIL starve_forced got bpu=%b exu=%b want 1 0", bus.bpu_rs1_gnt, bus.exu_rs1_gnt);
        end
        bus.rf_rs1_rdata = 32'hCAFE_0009;
        tick();
        checks++;
        if (bus.exu_rs1_gnt !== 1'b1 || bus.bpu_rs1_gnt !== 1'b0) begin
            errors++;
            $display("FAIL starve_rd_exu got exu=%b bpu=%b want 1 0", bus.exu_rs1_gnt, bus.bpu_rs1_gnt);
        end
        tick();
        checks++;
        if (bus.rs1_vld !== 1'b1 || bus.rs1_val !== 32'hCAFE_0009) begin
            errors++;
            $display("FAIL starve_hold got vld=%b val=%h want 1 cafe0009", bus.rs1_vld, bus.rs1_val);
        end
        bus.exu_rs1_req = 1'b0;
        release_jalr();
    endtask

    task automatic test_arb_drop();
        bus.exu_rs1_req = 1'b1;
        bus.jalr_req = 1'b1; bus.dep_clr = 1'b1; bus.jalr_rs1idx = 5'd10;
        tick(); tick(); tick();         // ARB with two EXU wins recorded
        bus.jalr_req = 1'b0;
        tick();                         // back to IDLE, counter cleared
        checks++;
        if (bus.bpu_wait !== 1'b0 || bus.bpu_rs1_gnt !== 1'b0) begin
            errors++;
            $display("FAIL drop_idle got wait=%b gnt=%b want 0 0", bus.bpu_wait, bus.bpu_rs1_gnt);
        end
        bus.jalr_req = 1'b1;
        tick();                         // ARB again
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (bus.exu_rs1_gnt !== 1'b1 || bus.bpu_rs1_gnt !== 1'b0) begin
                errors++;
                $display("FAIL drop_starve_clear cyc=%0d got exu=%b bpu=%b want 1 0", i, bus.exu_rs1_gnt, bus.bpu_rs1_gnt);
            end
            tick();
        end
        checks++;
        if (bus.bpu_rs1_gnt !== 1'b1) begin
            errors++;
            $display("FAIL drop_forced got bpu=%b want 1", bus.bpu_rs1_gnt);
        end
        bus.rf_rs1_rdata = 32'h0000_00AA;
        tick(); tick();
        bus.exu_rs1_req = 1'b0;
        release_jalr();
    endtask

    task automatic test_flush_rd();
        bus.jalr_req = 1'b1; bus.dep_clr = 1'b1; bus.jalr_rs1idx = 5'd3;
        tick();                         // ARB
        bus.rf_rs1_rdata = 32'h0BAD_0003;
        tick();                         // RD
        bus.flush = 1'b1;
        tick();                         // IDLE, data discarded
        bus.flush = 1'b0;
        checks++;
        if (bus.rs1_vld !== 1'b0 || bus.rs1_val !== 32'h0000_00AA || bus.bpu_rs1_gnt !== 1'b0) begin
            errors++;
            $display("FAIL flush_rd got vld=%b val=%h gnt=%b want 0 000000aa 0", bus.rs1_vld, bus.rs1_val, bus.bpu_rs1_gnt);
        end
        tick();                         // ARB
        checks++;
        if (bus.bpu_rs1_gnt !== 1'b1 || bus.rf_rs1_idx !== 5'd3) begin
            errors++;
            $display("FAIL flush_regnt got gnt=%b idx=%0d want 1 3", bus.bpu_rs1_gnt, bus.rf_rs1_idx);
        end
        bus.rf_rs1_rdata = 32'h0000_0033;
        tick(); tick();
        checks++;
        if (bus.rs1_vld !== 1'b1 || bus.rs1_val !== 32'h0000_0033) begin
            errors++;
            $display("FAIL flush_recover got vld=%b val=%h want 1 00000033", bus.rs1_vld, bus.rs1_val);
        end
        release_jalr();
    endtask

    task automatic test_hold();
        to_hold(5'd6, 32'h55AA_55AA);
        bus.jalr_req = 1'b0;
        bus.rf_rs1_rdata = 32'hFFFF_FFFF;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (bus.rs1_vld !== 1'b1 || bus.rs1_val !== 32'h55AA_55AA) begin
                errors++;
                $display("FAIL hold_stable cyc=%0d got vld=%b val=%h want 1 55aa55aa", i, bus.rs1_vld, bus.rs1_val);
            end
        end
        bus.jalr_ack = 1'b1;
        tick();
        bus.jalr_ack = 1'b0;
        checks++;
        if (bus.rs1_vld !== 1'b0 || bus.rs1_val !== 32'h55AA_55AA) begin
            errors++;
            $display("FAIL hold_ack got vld=%b val=%h want 0 55aa55aa", bus.rs1_vld, bus.rs1_val);
        end
    endtask

`ifdef IFU_JALR_RS1_CACHE_EN
    task automatic test_cache();
        to_hold(5'd5, 32'h1111_0005);
        release_jalr();
        bus.jalr_req = 1'b1; bus.dep_clr = 1'b1; bus.jalr_rs1idx = 5'd5;
        bus.rf_rs1_rdata = 32'hDEAD_BEEF;
        #1;
        checks++;
        if (bus.bpu_rs1_gnt !== 1'b0) begin
            errors++;
            $display("FAIL cache_no_gnt got %b want 0", bus.bpu_rs1_gnt);
        end
        tick();
        checks++;
        if (bus.rs1_vld !== 1'b1 || bus.rs1_val !== 32'h1111_0005) begin
            errors++;
            $display("FAIL cache_hit got vld=%b val=%h want 1 11110005", bus.rs1_vld, bus.rs1_val);
        end
        release_jalr();
        bus.wb_ena = 1'b1; bus.wb_idx = 5'd5;
        tick();
        bus.wb_ena = 1'b0;
        bus.jalr_req = 1'b1; bus.dep_clr = 1'b1; bus.jalr_rs1idx = 5'd5;
        tick();
        checks++;
        if (bus.bpu_rs1_gnt !== 1'b1 || bus.rs1_vld !== 1'b0) begin
            errors++;
            $display("FAIL cache_inval got gnt=%b vld=%b want 1 0", bus.bpu_rs1_gnt, bus.rs1_vld);
        end
        bus.rf_rs1_rdata = 32'h2222_0005;
        tick(); tick();
        release_jalr();
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic();
        test_dep();
        test_starve();
        test_arb_drop();
        test_flush_rd();
        test_hold();
`ifdef IFU_JALR_RS1_CACHE_EN
        test_cache();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Grants must never overlap at any sampled point.
    always @(negedge clk) begin
        if (rst_n && bus.exu_rs1_gnt && bus.bpu_rs1_gnt) begin
            checks++;
            errors++;
            $display("FAIL grant_overlap got exu=1 bpu=1 want exclusive");
        end
    end

endmodule
